// File: rtl/alu_regfile_ctrl.sv
// Four-entry 4-bit register file sequencing an external combinational ALU
// through an IDLE -> EXEC -> WB command pipeline, with immediate loads and a debug read port.
module alu_regfile_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_res,
    input  logic       alu_cout,
    output logic       done,
    output logic       carry_flag,
    output logic       zero_flag,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] regs_q [4];
    logic [1:0] op_q, rd_q, rs1_q, rs2_q;
    logic [3:0] res_q;
    logic       cout_q;
    logic       carry_q, zero_q;
    logic       accept;

    assign accept     = cmd_valid && cmd_ready;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign dbg_data   = regs_q[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU operands are only presented in EXEC so the ALU sees zeros otherwise.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !ld_en && !rst;
                if (cmd_valid && !ld_en && !rst) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a   = regs_q[rs1_q];
                alu_b   = regs_q[rs2_q];
                alu_op  = op_q;
                state_d = WB;
            end
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q  <= '{default: '0};
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_en) begin
                        regs_q[ld_addr] <= ld_data;
                    end else if (accept) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                    end
                end
                EXEC: begin
                    res_q  <= alu_res;
                    cout_q <= alu_cout;
                end
                WB: begin
                    regs_q[rd_q] <= res_q;
                    carry_q      <= cout_q;
                    zero_q       <= (res_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Self-checking bench for alu_regfile_ctrl: directed table, hand-written reset/load
// corner sequences, and randomized commands checked against an arithmetic register-file model.
module tb_alu_regfile_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_res;
    logic       alu_cout;
    logic       done, carry_flag, zero_flag;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mr [4];
    logic       mc, mz;

    always #5 clk = ~clk;

    alu_regfile_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .done       (done),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // The 4-bit ALU stage the controller drives.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'd0: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1: begin
                alu_res  = alu_a - alu_b;
                alu_cout = (alu_a >= alu_b);
            end
            2'd2: alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {carry, result} from plain integer arithmetic.
    function automatic logic [4:0] calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int s;
        case (op)
            2'd0: begin
                s = int'(a) + int'(b);
                return {(s > 15), 4'(s % 16)};
            end
            2'd1: begin
                s = int'(a) - int'(b);
                return {(s >= 0), 4'((s + 16) % 16)};
            end
            2'd2: return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 4; i++) mr[i] = '0;
        mc = 1'b0;
        mz = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk({tag, "_dbg"}, {4'h0, dbg_data}, {4'h0, mr[i]});
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        #1;
        chk("ld_blocks_ready", {7'h0, cmd_ready}, 8'h0);
        tick;
        ld_en = 1'b0;
        mr[a] = d;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        logic [4:0] e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        #1;
        chk("ready_idle", {7'h0, cmd_ready}, 8'h1);
        e = calc(op, mr[rs1], mr[rs2]);
        tick;
        // Scramble command inputs after accept; the latched command must be used.
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_rd    = 2'($urandom);
        cmd_rs1   = 2'($urandom);
        cmd_rs2   = 2'($urandom);
        #1;
        chk("exec_alu_a", {4'h0, alu_a}, {4'h0, mr[rs1]});
        chk("exec_alu_b", {4'h0, alu_b}, {4'h0, mr[rs2]});
        chk("exec_alu_op", {6'h0, alu_op}, {6'h0, op});
        chk("exec_done", {7'h0, done}, 8'h0);
        chk("exec_ready", {7'h0, cmd_ready}, 8'h0);
        tick;
        chk("wb_done", {7'h0, done}, 8'h1);
        chk("wb_alu_a", {4'h0, alu_a}, 8'h0);
        chk("wb_carry_hold", {7'h0, carry_flag}, {7'h0, mc});
        tick;
        cmd_valid = 1'b0;
        mr[rd] = e[3:0];
        mc     = e[4];
        mz     = (e[3:0] == 4'h0);
        chk("post_done", {7'h0, done}, 8'h0);
        chk("carry_flag", {7'h0, carry_flag}, {7'h0, mc});
        chk("zero_flag", {7'h0, zero_flag}, {7'h0, mz});
        check_regs("post_cmd");
    endtask

    typedef struct {
        logic [1:0] op, rd, rs1, rs2;
        logic [3:0] va, vb, res;
        logic       c, z;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [4:0] e;
        tbl[0] = '{2'd0, 2'd0, 2'd1, 2'd2, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0};
        tbl[1] = '{2'd1, 2'd3, 2'd2, 2'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
        tbl[2] = '{2'd1, 2'd3, 2'd1, 2'd2, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0};
        tbl[3] = '{2'd1, 2'd0, 2'd1, 2'd1, 4'h5, 4'h5, 4'h0, 1'b1, 1'b1};
        tbl[4] = '{2'd2, 2'd1, 2'd1, 2'd2, 4'h5, 4'h3, 4'h1, 1'b0, 1'b0};
        tbl[5] = '{2'd3, 2'd1, 2'd1, 2'd2, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0};
        tbl[6] = '{2'd0, 2'd2, 2'd0, 2'd3, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
        tbl[7] = '{2'd0, 2'd3, 2'd3, 2'd3, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        model_reset();
        tick;
        chk("ready_in_reset", {7'h0, cmd_ready}, 8'h0);
        chk("done_in_reset", {7'h0, done}, 8'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {7'h0, cmd_ready}, 8'h1);
        check_regs("reset");

        foreach (tbl[k]) begin
            load(tbl[k].rs1, tbl[k].va);
            load(tbl[k].rs2, tbl[k].vb);
            run_cmd(tbl[k].op, tbl[k].rd, tbl[k].rs1, tbl[k].rs2);
            dbg_addr = tbl[k].rd;
            #1;
            chk("tbl_res", {4'h0, dbg_data}, {4'h0, tbl[k].res});
            chk("tbl_carry", {7'h0, carry_flag}, {7'h0, tbl[k].c});
            chk("tbl_zero", {7'h0, zero_flag}, {7'h0, tbl[k].z});
        end

        // Load and command in the same IDLE cycle: load wins, command accepted next cycle.
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'h9;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd3; cmd_rs2 = 2'd1;
        #1;
        chk("ld_cmd_ready", {7'h0, cmd_ready}, 8'h0);
        tick;
        mr[3] = 4'h9;
        ld_en = 1'b0;
        #1;
        chk("held_cmd_ready", {7'h0, cmd_ready}, 8'h1);
        e = calc(2'd0, mr[3], mr[1]);
        tick;
        cmd_valid = 1'b0;
        chk("held_cmd_alu_a", {4'h0, alu_a}, 8'h09);
        chk("held_cmd_alu_b", {4'h0, alu_b}, {4'h0, mr[1]});
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = ~mr[1];
        tick;
        ld_addr = 2'd2; ld_data = ~mr[2];
        tick;
        ld_en = 1'b0;
        mr[0] = e[3:0]; mc = e[4]; mz = (e[3:0] == 4'h0);
        chk("held_cmd_carry", {7'h0, carry_flag}, {7'h0, mc});
        check_regs("ld_ignored");

        // Asynchronous reset mid-cycle during EXEC clears everything without a clock edge.
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd3;
        tick;
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_alu_a", {4'h0, alu_a}, 8'h0);
        chk("rst_alu_b", {4'h0, alu_b}, 8'h0);
        chk("rst_alu_op", {6'h0, alu_op}, 8'h0);
        chk("rst_done", {7'h0, done}, 8'h0);
        chk("rst_carry", {7'h0, carry_flag}, 8'h0);
        chk("rst_zero", {7'h0, zero_flag}, 8'h0);
        chk("rst_ready", {7'h0, cmd_ready}, 8'h0);
        check_regs("async_rst");
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {7'h0, cmd_ready}, 8'h1);

        // Reset pulse during EXEC of ADD into R0 aborts it; next command completes.
        load(2'd1, 4'h5);
        load(2'd2, 4'h3);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
        tick;
        cmd_valid = 1'b0;
        #2; rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort_no_done", {7'h0, done}, 8'h0);
        end
        check_regs("abort");
        load(2'd1, 4'h5);
        load(2'd2, 4'h3);
        run_cmd(2'd0, 2'd0, 2'd1, 2'd2);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                load(2'($urandom), 4'($urandom));
            else
                run_cmd(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
